ber_sweep_ctrl: RTL and testbench
=================================

# ber_sweep_ctrl

Sequencing controller for the LDPC bit-error-rate measurement harness. It steps the channel SNR index over a configured range. At each SNR point it launches decoder frames whenever the noise-generator buffers are full, then counts decoded frames and frame errors. A point closes when either the error target or the frame limit is reached; the controller then emits one result record and moves to the next SNR point. It sits between the noise-generator/quantiser bank and the decoder core, and replaces free-running frame launch with a deterministic sweep.

## Interface
- SNR_W, 4, width of SNR index
- SNR_MIN, 0, first SNR index of sweep
- SNR_MAX, 10, last SNR index of sweep (SNR_MAX >= SNR_MIN)
- FRAME_W, 16, width of frame counter
- ERR_W, 12, width of error counter
- MAX_FRAMES, 1000, frame limit per SNR point (1 .. 2^FRAME_W-1)
- ERR_TARGET, 100, frame-error target per SNR point (1 .. 2^ERR_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE
- abort  in  1  synchronous abort; returns the controller to IDLE
- gen_ready  in  1  AND of all noise-buffer full flags
- dec_term  in  1  decoder finished current frame (level)
- dec_err  in  1  frame error flag, qualified by dec_term
- frame_start  out  1  one-cycle pulse: load LLRs, reset/enable decoder, clear noise buffers
- dec_en  out  1  decoder enable
- snr_idx  out  SNR_W  current SNR index to quantisers
- busy  out  1  sweep in progress
- done  out  1  sweep complete (sticky until start/abort/rst)
- rec_valid  out  1  one-cycle pulse: record fields valid
- rec_snr  out  SNR_W  SNR index of record
- rec_frames  out  FRAME_W  frames decoded at that point
- rec_errs  out  ERR_W  frame errors at that point

## Operation
- States: IDLE, WAIT_GEN, DECODE, ACCOUNT, REPORT, DONE.
- IDLE: on start, load snr_idx=SNR_MIN and clear the counters, then go to WAIT_GEN.
- WAIT_GEN: when gen_ready=1, assert frame_start for one cycle and go to DECODE.
- DECODE: dec_en=1.
  - dec_term is ignored in the first DECODE cycle, because the decoder is still in reset.
  - From the second cycle on, dec_term=1 moves the FSM to ACCOUNT.
- ACCOUNT (one cycle):
  - frames += 1.
  - errs += dec_err, saturating at 2^ERR_W-1. dec_err is sampled in the same cycle dec_term was seen.
  - Uses the updated counts: if errs >= ERR_TARGET or frames >= MAX_FRAMES, go to REPORT; else go to WAIT_GEN.
- REPORT (one cycle):
  - rec_valid=1 with rec_snr/rec_frames/rec_errs = current values.
  - If snr_idx==SNR_MAX, go to DONE.
  - Otherwise snr_idx+=1, clear the counters, and go to WAIT_GEN.
- DONE: done=1. snr_idx holds SNR_MAX. start restarts the sweep as from IDLE.
- busy=1 in WAIT_GEN, DECODE, ACCOUNT and REPORT.
- start while busy is ignored.
- abort has priority over every other input.
  - From any state, the next state is IDLE: counters cleared, dec_en=0, no rec_valid, done=0.
- gen_ready outside WAIT_GEN is ignored.
- dec_term outside DECODE is ignored.
- snr_idx never wraps; its increment is gated by the SNR_MAX compare.
- Counter widths: frames compare is FRAME_W unsigned; errs compare is ERR_W unsigned.

## Timing
- Reset values:
  - State IDLE.
  - snr_idx=SNR_MIN.
  - frame_start=0, dec_en=0, busy=0, done=0.
  - rec_valid=0, rec_snr=0, rec_frames=0, rec_errs=0.
  - Internal counters 0.
- All outputs are registered.
- start sampled at cycle t gives busy=1 at t+1.
- gen_ready high at t (in WAIT_GEN) gives frame_start=1 at t+1 and dec_en=1 from t+1.
- dec_term high at t (in DECODE, at least the second DECODE cycle) gives ACCOUNT at t+1, then REPORT or WAIT_GEN at t+2.
- rec_valid high for exactly 1 cycle. The rec_* fields hold their values until the next rec_valid.
- The new snr_idx is visible the cycle after rec_valid, before any new frame_start.
- Minimum frame loop, with gen_ready constant 1 and dec_term immediate: 4 cycles per frame.
- rst mid-sweep: immediate return to the reset values; no record emitted.

## Test plan
- Short sweep. SNR_MIN=2, SNR_MAX=4, MAX_FRAMES=3, ERR_TARGET=100; dec_err=0 always; start.
  - Expect 3 records: (2,3,0), (3,3,0), (4,3,0).
  - Then done=1, busy=0, and exactly 9 frame_start pulses.
- Error target. MAX_FRAMES=1000, ERR_TARGET=5; dec_err=1 on every frame.
  - Expect record (SNR_MIN,5,5) after the 5th frame.
- Back-pressure. Hold gen_ready=0 for 50 cycles in WAIT_GEN.
  - Expect no frame_start and dec_en=0.
  - Raise gen_ready: expect frame_start exactly 1 cycle later.
- Early term. Hold dec_term=1 continuously.
  - Expect the first DECODE cycle ignored.
  - Expect frames to increment once per frame_start, never twice.
- Abort and start collisions.
  - Assert abort during DECODE with 2 frames counted: expect IDLE next cycle, no rec_valid, dec_en=0.
  - Start pulsed while busy: expect no effect.
- Async reset mid-REPORT.
  - Expect rec_valid=0 and snr_idx=SNR_MIN immediately, without a clock edge.
  - Restart the sweep: expect identical records to an uninterrupted run.

Source files
------------

// File: rtl/ber_sweep_if.sv
// Handshake bundle between the BER sweep controller and the noise-generator / decoder harness.
interface ber_sweep_if #(
  parameter int SNR_W   = 4,
  parameter int FRAME_W = 16,
  parameter int ERR_W   = 12
);
  logic               start;
  logic               abort;
  logic               gen_ready;
  logic               dec_term;
  logic               dec_err;
  logic               frame_start;
  logic               dec_en;
  logic [SNR_W-1:0]   snr_idx;
  logic               busy;
  logic               done;
  logic               rec_valid;
  logic [SNR_W-1:0]   rec_snr;
  logic [FRAME_W-1:0] rec_frames;
  logic [ERR_W-1:0]   rec_errs;

  modport master (
    input  start, abort, gen_ready, dec_term, dec_err,
    output frame_start, dec_en, snr_idx, busy, done,
    output rec_valid, rec_snr, rec_frames, rec_errs
  );

  modport slave (
    output start, abort, gen_ready, dec_term, dec_err,
    input  frame_start, dec_en, snr_idx, busy, done,
    input  rec_valid, rec_snr, rec_frames, rec_errs
  );
endinterface

// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: steps the SNR index, launches decoder frames when the noise buffers
// are full, counts frames/frame errors per point and emits one result record per point.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no sweep; waiting for start
// WAIT_GEN | waiting for all noise buffers full (gen_ready)
// DECODE   | decoder running; dec_term ignored in its first cycle
// ACCOUNT  | counters already updated; decide close-point or next frame
// REPORT   | rec_valid pulse; advance SNR index or finish
// DONE     | sweep complete; start restarts from SNR_MIN
module ber_sweep_ctrl #(
  parameter int SNR_W      = 4,
  parameter int SNR_MIN    = 0,
  parameter int SNR_MAX    = 10,
  parameter int FRAME_W    = 16,
  parameter int ERR_W      = 12,
  parameter int MAX_FRAMES = 1000,
  parameter int ERR_TARGET = 100
) (
  input  logic       clk,
  input  logic       rst,
  ber_sweep_if.master bus
);

  localparam logic [SNR_W-1:0]   SNR_MIN_V    = SNR_W'(SNR_MIN);
  localparam logic [SNR_W-1:0]   SNR_MAX_V    = SNR_W'(SNR_MAX);
  localparam logic [FRAME_W-1:0] MAX_FRAMES_V = FRAME_W'(MAX_FRAMES);
  localparam logic [ERR_W-1:0]   ERR_TARGET_V = ERR_W'(ERR_TARGET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GEN,
    S_DECODE,
    S_ACCOUNT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SNR_W-1:0]   snr_q;
  logic [FRAME_W-1:0] frames;
  logic [ERR_W-1:0]   errs;
  logic [SNR_W-1:0]   rec_snr_q;
  logic [FRAME_W-1:0] rec_frames_q;
  logic [ERR_W-1:0]   rec_errs_q;

  logic frame_start_q, dec_en_q, busy_q, done_q, rec_valid_q;
  logic frame_start_nxt, dec_en_nxt, busy_nxt, done_nxt, rec_valid_nxt;

  logic term_ok;
  logic point_full;
  logic last_point;

  // frame_start is high exactly during the first DECODE cycle, while the decoder is in reset
  assign term_ok    = bus.dec_term && !frame_start_q;
  assign point_full = (errs >= ERR_TARGET_V) || (frames >= MAX_FRAMES_V);
  assign last_point = (snr_q == SNR_MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      frame_start_q <= 1'b0;
      dec_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rec_valid_q   <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_start_q <= frame_start_nxt;
      dec_en_q      <= dec_en_nxt;
      busy_q        <= busy_nxt;
      done_q        <= done_nxt;
      rec_valid_q   <= rec_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) state_nxt = S_WAIT_GEN;
        S_WAIT_GEN:     if (bus.gen_ready) state_nxt = S_DECODE;
        S_DECODE:       if (term_ok) state_nxt = S_ACCOUNT;
        S_ACCOUNT:      state_nxt = point_full ? S_REPORT : S_WAIT_GEN;
        S_REPORT:       state_nxt = last_point ? S_DONE : S_WAIT_GEN;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    frame_start_nxt = (state == S_WAIT_GEN) && (state_nxt == S_DECODE);
    dec_en_nxt      = (state_nxt == S_DECODE);
    busy_nxt        = (state_nxt == S_WAIT_GEN) || (state_nxt == S_DECODE) ||
                      (state_nxt == S_ACCOUNT)  || (state_nxt == S_REPORT);
    done_nxt        = (state_nxt == S_DONE);
    rec_valid_nxt   = (state_nxt == S_REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snr_q        <= SNR_MIN_V;
      frames       <= '0;
      errs         <= '0;
      rec_snr_q    <= '0;
      rec_frames_q <= '0;
      rec_errs_q   <= '0;
    end else if (bus.abort) begin
      snr_q  <= SNR_MIN_V;
      frames <= '0;
      errs   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            snr_q  <= SNR_MIN_V;
            frames <= '0;
            errs   <= '0;
          end
        end
        S_DECODE: begin
          // counts are bumped on the way into ACCOUNT so its decision sees updated values
          if (term_ok) begin
            frames <= frames + 1'b1;
            if (bus.dec_err && (errs != '1)) errs <= errs + 1'b1;
          end
        end
        S_ACCOUNT: begin
          if (point_full) begin
            rec_snr_q    <= snr_q;
            rec_frames_q <= frames;
            rec_errs_q   <= errs;
          end
        end
        S_REPORT: begin
          if (!last_point) begin
            snr_q  <= snr_q + 1'b1;
            frames <= '0;
            errs   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.dec_en      = dec_en_q;
  assign bus.snr_idx     = snr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rec_valid   = rec_valid_q;
  assign bus.rec_snr     = rec_snr_q;
  assign bus.rec_frames  = rec_frames_q;
  assign bus.rec_errs    = rec_errs_q;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Directed bench for ber_sweep_ctrl: per-frame vector table plus abort and async-reset sequences.
module tb_ber_sweep_ctrl;

  localparam int SNR_W      = 4;
  localparam int FRAME_W    = 16;
  localparam int ERR_W      = 12;
  localparam int SNR_MIN    = 2;
  localparam int SNR_MAX    = 4;
  localparam int MAX_FRAMES = 3;
  localparam int ERR_TARGET = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ber_sweep_if #(.SNR_W(SNR_W), .FRAME_W(FRAME_W), .ERR_W(ERR_W)) bus ();

  ber_sweep_ctrl #(
    .SNR_W(SNR_W), .SNR_MIN(SNR_MIN), .SNR_MAX(SNR_MAX), .FRAME_W(FRAME_W),
    .ERR_W(ERR_W), .MAX_FRAMES(MAX_FRAMES), .ERR_TARGET(ERR_TARGET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // one entry per frame: expected SNR, gen_ready wait, dec_term delay, error flag,
  // start poke during the wait, and the record expected after this frame (if any)
  typedef struct {
    int snr;
    int gw;
    int tw;
    bit err;
    bit poke;
    bit rec;
    int r_fr;
    int r_er;
  } vec_t;

  vec_t vt[32];
  int   nv = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fs_cnt = 0;
  int   rst_idx = -1;

  always @(posedge clk) if (bus.frame_start === 1'b1) fs_cnt++;

  function automatic void add(int snr, int gw, int tw, bit err, bit poke, bit rec, int fr, int er);
    vt[nv] = '{snr, gw, tw, err, poke, rec, fr, er};
    nv++;
  endfunction

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // entered and left at a falling edge with the controller in WAIT_GEN (or DONE after the last record)
  task automatic do_frame(input int k);
    int n;
    bit bad;
    check("wait_snr_idx", int'(bus.snr_idx), vt[k].snr);
    check("wait_busy", int'(bus.busy), 1);
    bad = 1'b0;
    bus.gen_ready = 1'b0;
    for (int i = 0; i < vt[k].gw; i++) begin
      bus.start = vt[k].poke && (i == 1);
      @(negedge clk);
      if (bus.frame_start || bus.dec_en) bad = 1'b1;
    end
    bus.start = 1'b0;
    if (vt[k].gw > 0) check("backpressure_quiet", int'(bad), 0);
    bus.gen_ready = 1'b1;
    @(negedge clk);
    bus.gen_ready = 1'b0;
    check("frame_start", int'(bus.frame_start), 1);
    check("dec_en_on", int'(bus.dec_en), 1);
    bad = 1'b0;
    for (int i = 0; i < vt[k].tw; i++) begin
      @(negedge clk);
      if (bus.frame_start || !bus.dec_en) bad = 1'b1;
    end
    if (vt[k].tw > 0) check("decode_hold", int'(bad), 0);
    bus.dec_term = 1'b1;
    bus.dec_err  = vt[k].err;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dec_en && n < 6);
    check("term_latency", n, (vt[k].tw == 0) ? 2 : 1);
    check("account_no_fs", int'(bus.frame_start), 0);
    bus.dec_term = 1'b0;
    bus.dec_err  = 1'b0;
    @(negedge clk);
    check("rec_valid", int'(bus.rec_valid), int'(vt[k].rec));
    if (vt[k].rec) begin
      check("rec_snr", int'(bus.rec_snr), vt[k].snr);
      check("rec_frames", int'(bus.rec_frames), vt[k].r_fr);
      check("rec_errs", int'(bus.rec_errs), vt[k].r_er);
      if (rst_idx == k) begin
        rst = 1'b1;
        #1;
        check("rst_rec_valid", int'(bus.rec_valid), 0);
        check("rst_snr_idx", int'(bus.snr_idx), SNR_MIN);
        check("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      check("rec_pulse_end", int'(bus.rec_valid), 0);
      check("rec_frames_hold", int'(bus.rec_frames), vt[k].r_fr);
      if (vt[k].snr == SNR_MAX) begin
        check("done", int'(bus.done), 1);
        check("done_busy", int'(bus.busy), 0);
        check("done_snr_idx", int'(bus.snr_idx), SNR_MAX);
      end else begin
        check("next_snr_idx", int'(bus.snr_idx), vt[k].snr + 1);
        check("next_no_fs", int'(bus.frame_start), 0);
      end
    end else begin
      check("loop_busy", int'(bus.busy), 1);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    int fs0;
    fs0 = fs_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", int'(bus.busy), 1);
    check("start_done", int'(bus.done), 0);
    for (int k = lo; k <= hi; k++) do_frame(k);
    check("frame_start_count", fs_cnt - fs0, hi - lo + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // sweep A: mixed delays, errors, back-pressure, early term, start poke while busy
    add(2, 0, 1, 0, 0, 0, 0, 0);
    add(2, 50, 0, 0, 0, 0, 0, 0);
    add(2, 0, 2, 0, 0, 1, 3, 0);
    add(3, 1, 1, 1, 0, 0, 0, 0);
    add(3, 4, 0, 0, 1, 0, 0, 0);
    add(3, 2, 1, 0, 0, 1, 3, 1);
    add(4, 0, 1, 1, 0, 0, 0, 0);
    add(4, 0, 0, 1, 0, 1, 2, 2);
    // sweep B (idx 8..16): frame limit closes every point, minimum frame loop
    for (int s = SNR_MIN; s <= SNR_MAX; s++) begin
      add(s, 0, 1, 0, 0, 0, 0, 0);
      add(s, 0, 1, 0, 0, 0, 0, 0);
      add(s, 0, 1, 0, 0, 1, 3, 0);
    end
    // sweep C (idx 17..22): error target closes every point
    for (int s = SNR_MIN; s <= SNR_MAX; s++) begin
      add(s, 0, 1, 1, 0, 0, 0, 0);
      add(s, 0, 1, 1, 0, 1, 2, 2);
    end

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.gen_ready = 1'b0;
    bus.dec_term = 1'b0;
    bus.dec_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_dec_en", int'(bus.dec_en), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);
    check("rst_rec_valid", int'(bus.rec_valid), 0);
    check("rst_rec_fields", int'(bus.rec_snr) + int'(bus.rec_frames) + int'(bus.rec_errs), 0);
    check("rst_snr_idx", int'(bus.snr_idx), SNR_MIN);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_busy", int'(bus.busy), 0);

    run_range(0, 7);
    run_range(8, 16);
    run_range(17, 22);

    // abort during DECODE with two frames counted, start pulsed while busy
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    do_frame(8);
    do_frame(9);
    bus.gen_ready = 1'b1;
    @(negedge clk);
    bus.gen_ready = 1'b0;
    check("ab_frame_start", int'(bus.frame_start), 1);
    bus.start = 1'b1;
    bus.dec_term = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ab_start_ignored_dec_en", int'(bus.dec_en), 1);
    check("ab_start_ignored_snr", int'(bus.snr_idx), SNR_MIN);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.dec_term = 1'b0;
    check("ab_busy", int'(bus.busy), 0);
    check("ab_dec_en", int'(bus.dec_en), 0);
    check("ab_rec_valid", int'(bus.rec_valid), 0);
    check("ab_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    check("ab_idle_rec_valid", int'(bus.rec_valid), 0);
    check("ab_idle_busy", int'(bus.busy), 0);
    run_range(8, 16);

    // async reset in REPORT of the second point, then a clean sweep must repeat sweep B
    rst_idx = 13;
    run_range(8, 13);
    rst_idx = -1;
    check("post_rst_busy", int'(bus.busy), 0);
    run_range(8, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
